// File: rtl/rv32_decoder_pkg.sv
// Shared constants and types for the RV32I decode stage: opcodes, ALU and
// branch control encodings, immediate formats and the decoded-bundle struct.
package rv32_decoder_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGE  = 3'b100;
  localparam logic [2:0] BR_BLTU = 3'b101;
  localparam logic [2:0] BR_BGEU = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  // One decoded instruction; all-zero is the NOP encoding.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_ctrl;
    logic        w_en;
    logic [31:0] imm;
    logic        op1_sel;
    logic [2:0]  branch_ctrl;
    logic [31:0] jump_offset;
    logic        jump_en;
    logic        jump_reg;
  } dec_t;

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational immediate extraction; every format sign-extends from inst[31].
module rv32_imm_gen
  import rv32_decoder_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  // Reassemble the immediate bits scattered across the instruction word.
  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U: imm = {inst[31:12], 12'b0};
      IMM_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/rv32_decoder.sv
// Registered RV32I decode stage (one cycle latency, en = capture, rst wins).
// Optional: define DECODER_ILLEGAL_INST_EN to add a registered 'illegal' flag
// for unsupported opcodes/funct fields; otherwise such words decode as NOP.
module rv32_decoder
  import rv32_decoder_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [31:0]     inst,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [3:0]      alu_ctrl,
  output logic            w_en,
  output logic [XLEN-1:0] imm,
  output logic            op1_sel,
  output logic [2:0]      branch_ctrl,
  output logic [XLEN-1:0] jump_offset,
  output logic            jump_en,
`ifdef DECODER_ILLEGAL_INST_EN
  output logic            illegal,
`endif
  output logic            jump_reg
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] f_rs1, f_rs2, f_rd;
  imm_fmt_e   fmt;
  logic [31:0] gen_imm;
  logic       legal;
  dec_t       dec_d, dec_q;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign f_rs1  = inst[19:15];
  assign f_rs2  = inst[24:20];
  assign f_rd   = inst[11:7];

  // Immediate format depends only on the opcode; JAL/JALR route theirs to jump_offset.
  always_comb begin
    fmt = IMM_I;
    case (opcode)
      OPC_STORE:           fmt = IMM_S;
      OPC_BRANCH:          fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:  fmt = IMM_U;
      OPC_JAL:             fmt = IMM_J;
      default:             fmt = IMM_I;
    endcase
  end

  rv32_imm_gen #(.XLEN(32)) u_imm_gen (
    .inst (inst),
    .fmt  (fmt),
    .imm  (gen_imm)
  );

  // Decode into a bundle; anything not recognised collapses to all-zero (NOP).
  always_comb begin
    dec_d = '0;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE ||
            (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          legal          = 1'b1;
          dec_d.rs1      = f_rs1;
          dec_d.rs2      = f_rs2;
          dec_d.rd       = f_rd;
          dec_d.alu_ctrl = {inst[30], funct3};
          dec_d.w_en     = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_d.rs1  = f_rs1;
        dec_d.rd   = f_rd;
        dec_d.w_en = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shifts: funct7 selects SRL/SRA; only SRx may use the alternate form.
          legal          = (funct7 == F7_BASE) || (funct3 == 3'b101 && funct7 == F7_ALT);
          dec_d.alu_ctrl = {inst[30], funct3};
          dec_d.imm      = {27'b0, inst[24:20]};
        end else begin
          legal          = 1'b1;
          dec_d.alu_ctrl = {1'b0, funct3};
          dec_d.imm      = gen_imm;
        end
      end
      OPC_LOAD: begin
        legal          = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        dec_d.rs1      = f_rs1;
        dec_d.rd       = f_rd;
        dec_d.alu_ctrl = ALU_ADD;
        dec_d.w_en     = 1'b1;
        dec_d.imm      = gen_imm;
      end
      OPC_STORE: begin
        legal          = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        dec_d.rs1      = f_rs1;
        dec_d.rs2      = f_rs2;
        dec_d.alu_ctrl = ALU_ADD;
        dec_d.imm      = gen_imm;
      end
      OPC_BRANCH: begin
        legal          = (funct3 != 3'b010) && (funct3 != 3'b011);
        dec_d.rs1      = f_rs1;
        dec_d.rs2      = f_rs2;
        dec_d.alu_ctrl = ALU_SUB;
        dec_d.imm      = gen_imm;
        case (funct3)
          3'b000:  dec_d.branch_ctrl = BR_BEQ;
          3'b001:  dec_d.branch_ctrl = BR_BNE;
          3'b100:  dec_d.branch_ctrl = BR_BLT;
          3'b101:  dec_d.branch_ctrl = BR_BGE;
          3'b110:  dec_d.branch_ctrl = BR_BLTU;
          3'b111:  dec_d.branch_ctrl = BR_BGEU;
          default: dec_d.branch_ctrl = BR_NONE;
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        legal          = 1'b1;
        dec_d.rd       = f_rd;
        dec_d.alu_ctrl = ALU_ADD;
        dec_d.w_en     = 1'b1;
        dec_d.imm      = gen_imm;
        dec_d.op1_sel  = (opcode == OPC_AUIPC);
      end
      OPC_JAL, OPC_JALR: begin
        // Link value is PC+4 through the ALU; the target offset goes separately.
        legal             = (opcode == OPC_JAL) || (funct3 == 3'b000);
        dec_d.rs1         = (opcode == OPC_JALR) ? f_rs1 : 5'd0;
        dec_d.rd          = f_rd;
        dec_d.alu_ctrl    = ALU_ADD;
        dec_d.w_en        = 1'b1;
        dec_d.op1_sel     = 1'b1;
        dec_d.imm         = 32'd4;
        dec_d.jump_en     = 1'b1;
        dec_d.jump_reg    = (opcode == OPC_JALR);
        dec_d.jump_offset = gen_imm;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) dec_d = '0;
  end

  // Pipeline register: reset beats enable, enable low holds.
  always_ff @(posedge clk) begin
    if (rst)     dec_q <= '0;
    else if (en) dec_q <= dec_d;
  end

`ifdef DECODER_ILLEGAL_INST_EN
  // Illegal flag tracks the same capture/hold/reset behaviour as the bundle.
  always_ff @(posedge clk) begin
    if (rst)     illegal <= 1'b0;
    else if (en) illegal <= ~legal;
  end
`endif

  assign rs1         = dec_q.rs1;
  assign rs2         = dec_q.rs2;
  assign rd          = dec_q.rd;
  assign alu_ctrl    = dec_q.alu_ctrl;
  assign w_en        = dec_q.w_en;
  assign imm         = dec_q.imm;
  assign op1_sel     = dec_q.op1_sel;
  assign branch_ctrl = dec_q.branch_ctrl;
  assign jump_offset = dec_q.jump_offset;
  assign jump_en     = dec_q.jump_en;
  assign jump_reg    = dec_q.jump_reg;

endmodule

// File: tb/tb_rv32_decoder.sv
// Directed-vector bench for rv32_decoder with hand-computed expectations.
module tb_rv32_decoder;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [31:0] inst;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_ctrl;
  logic        w_en, op1_sel, jump_en, jump_reg;
  logic [31:0] imm, jump_offset;
  logic [2:0]  branch_ctrl;
`ifdef DECODER_ILLEGAL_INST_EN
  logic        illegal;
`endif

  int n_chk = 0;
  int n_err = 0;

  rv32_decoder #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .inst        (inst),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .alu_ctrl    (alu_ctrl),
    .w_en        (w_en),
    .imm         (imm),
    .op1_sel     (op1_sel),
    .branch_ctrl (branch_ctrl),
    .jump_offset (jump_offset),
    .jump_en     (jump_en),
`ifdef DECODER_ILLEGAL_INST_EN
    .illegal     (illegal),
`endif
    .jump_reg    (jump_reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Apply inputs away from the edge, clock once, sample just after the edge.
  task automatic step(input logic r, input logic e, input logic [31:0] i);
    @(negedge clk);
    rst = r; en = e; inst = i;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag,
                            input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                            input logic [4:0] e_rd, input logic [3:0] e_alu,
                            input logic e_wen, input logic [31:0] e_imm,
                            input logic e_op1, input logic [2:0] e_br,
                            input logic [31:0] e_joff, input logic e_jen,
                            input logic e_jreg, input logic e_ill);
    chk({tag, ".rs1"},  32'(rs1), 32'(e_rs1));
    chk({tag, ".rs2"},  32'(rs2), 32'(e_rs2));
    chk({tag, ".rd"},   32'(rd), 32'(e_rd));
    chk({tag, ".alu"},  32'(alu_ctrl), 32'(e_alu));
    chk({tag, ".wen"},  32'(w_en), 32'(e_wen));
    chk({tag, ".imm"},  imm, e_imm);
    chk({tag, ".op1"},  32'(op1_sel), 32'(e_op1));
    chk({tag, ".br"},   32'(branch_ctrl), 32'(e_br));
    chk({tag, ".joff"}, jump_offset, e_joff);
    chk({tag, ".jen"},  32'(jump_en), 32'(e_jen));
    chk({tag, ".jreg"}, 32'(jump_reg), 32'(e_jreg));
`ifdef DECODER_ILLEGAL_INST_EN
    chk({tag, ".ill"},  32'(illegal), 32'(e_ill));
`else
    if (e_ill) begin end
`endif
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; inst = 32'h00500093;
    // Reset held for two edges with a valid instruction present.
    step(1, 1, 32'h00500093);
    step(1, 1, 32'h00500093);
    expect_all("reset", 0, 0, 0, 4'b0000, 0, 32'h0, 0, 3'b000, 32'h0, 0, 0, 0);

    // addi x1, x0, 5
    step(0, 1, 32'h00500093);
    expect_all("addi", 0, 0, 1, 4'b0000, 1, 32'h5, 0, 3'b000, 32'h0, 0, 0, 0);

    // sub x3, x1, x2
    step(0, 1, 32'h402081B3);
    expect_all("sub", 1, 2, 3, 4'b1000, 1, 32'h0, 0, 3'b000, 32'h0, 0, 0, 0);

    // beq x1, x2, -8
    step(0, 1, 32'hFE208CE3);
    expect_all("beq", 1, 2, 0, 4'b1000, 0, 32'hFFFFFFF8, 0, 3'b001, 32'h0, 0, 0, 0);

    // jal x1, 16
    step(0, 1, 32'h010000EF);
    expect_all("jal", 0, 0, 1, 4'b0000, 1, 32'h4, 1, 3'b000, 32'h10, 1, 0, 0);

    // jalr x1, -4(x5)
    step(0, 1, 32'hFFC280E7);
    expect_all("jalr", 5, 0, 1, 4'b0000, 1, 32'h4, 1, 3'b000, 32'hFFFFFFFC, 1, 1, 0);

    // sw x2, 8(x1)
    step(0, 1, 32'h0020A423);
    expect_all("sw", 1, 2, 0, 4'b0000, 0, 32'h8, 0, 3'b000, 32'h0, 0, 0, 0);

    // srai x4, x3, 3 : shamt zero-extended, funct7 bit 30 kept
    step(0, 1, 32'h4031D213);
    expect_all("srai", 3, 0, 4, 4'b1101, 1, 32'h3, 0, 3'b000, 32'h0, 0, 0, 0);

    // auipc x7, 0xFFFFF
    step(0, 1, 32'hFFFFF397);
    expect_all("auipc", 0, 0, 7, 4'b0000, 1, 32'hFFFFF000, 1, 3'b000, 32'h0, 0, 0, 0);

    // OP with funct7=0000001 (M extension) -> NOP
    step(0, 1, 32'h022081B3);
    expect_all("badf7", 0, 0, 0, 4'b0000, 0, 32'h0, 0, 3'b000, 32'h0, 0, 0, 1);

    // branch funct3=010 unsupported -> NOP
    step(0, 1, 32'hFE20ACE3);
    expect_all("brf3", 0, 0, 0, 4'b0000, 0, 32'h0, 0, 3'b000, 32'h0, 0, 0, 1);

    // lui x5, 0x12345
    step(0, 1, 32'h123452B7);
    expect_all("lui", 0, 0, 5, 4'b0000, 1, 32'h12345000, 0, 3'b000, 32'h0, 0, 0, 0);

    // en=0 while inst changes: hold lui outputs
    step(0, 0, 32'h402081B3);
    expect_all("hold", 0, 0, 5, 4'b0000, 1, 32'h12345000, 0, 3'b000, 32'h0, 0, 0, 0);

    // all-zero word -> NOP
    step(0, 1, 32'h00000000);
    expect_all("zero", 0, 0, 0, 4'b0000, 0, 32'h0, 0, 3'b000, 32'h0, 0, 0, 1);

    // jal again then reset with en=1 mid-stream: reset wins
    step(0, 1, 32'h010000EF);
    chk("jal2.jen", 32'(jump_en), 32'd1);
    step(1, 1, 32'h402081B3);
    expect_all("rst_en", 0, 0, 0, 4'b0000, 0, 32'h0, 0, 3'b000, 32'h0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
